// File: rtl/sample_recorder.sv
// sample_recorder: arms on request, starts recording an 8-bit offset-binary
// audio stream when its magnitude crosses THRESH, and fills a DEPTH-entry
// sample RAM until stopped or full. A synchronous read port serves playback.
module sample_recorder #(
  parameter int          ADDR_W = 12,
  parameter int          DEPTH  = 4096,
  parameter logic [7:0]  THRESH = 8'd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              stop,
  input  logic              sample_valid,
  input  logic [7:0]        sample_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   rec_len,
  output logic              armed,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] REC   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [7:0]        mag;
  logic              trigger;
  logic              wr_en;
  logic              clear_len;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        mem [DEPTH];

  // The write pointer always equals the number of samples stored, so the
  // length register doubles as the pointer; it never reaches DEPTH while a
  // write is still possible, so the truncation below is safe.
  assign wr_ptr = rec_len[ADDR_W-1:0];

  assign armed = (state == ARMED);
  assign busy  = (state == REC);

  // Distance of the sample from the 128 silence level, in 8 bits.
  always_comb begin
    mag = 8'd0;
    if (sample_in >= 8'd128) begin
      mag = sample_in - 8'd128;
    end else begin
      mag = 8'd128 - sample_in;
    end
  end

  assign trigger = sample_valid && (mag >= THRESH);

  // Next-state and write decisions; stop beats a trigger while armed, and a
  // sample arriving with stop during recording is still kept.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    clear_len = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_nxt = ARMED;
          clear_len = 1'b1;
        end
      end
      ARMED: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (trigger) begin
          wr_en     = 1'b1;
          state_nxt = REC;
        end
      end
      REC: begin
        if (sample_valid) begin
          wr_en = 1'b1;
        end
        if (stop || (sample_valid && ((rec_len + LEN_ONE) == LEN_FULL))) begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control state, sample count and the one-cycle done pulse on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rec_len <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE) && (state != DONE);
      if (clear_len) begin
        rec_len <= '0;
      end else if (wr_en) begin
        rec_len <= rec_len + LEN_ONE;
      end
    end
  end

  // Sample RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // Registered read port, read-before-write on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 8'd0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_sample_recorder.sv
// Testbench for sample_recorder: directed scenarios followed by random
// traffic, every cycle compared against a behavioural recorder model.
module tb_sample_recorder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int THRESH = 16;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_REC   = 2;
  localparam int M_DONE  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm;
  logic              stop;
  logic              sample_valid;
  logic [7:0]        sample_in;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [ADDR_W:0]   rec_len;
  logic              armed;
  logic              busy;
  logic              done;

  int vectors     = 0;
  int miscompares = 0;

  int         m_mode;
  int         m_len;
  logic [7:0] m_mem   [DEPTH];
  bit         m_known [DEPTH];
  bit         m_done;
  logic [7:0] m_rd;
  bit         m_rd_known;

  sample_recorder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .THRESH (8'(THRESH))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .stop         (stop),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rec_len      (rec_len),
    .armed        (armed),
    .busy         (busy),
    .done         (done)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic int magnitude(logic [7:0] d);
    int x;
    x = int'(d) - 128;
    return (x < 0) ? -x : x;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("armed",   32'(armed),   32'(m_mode == M_ARMED));
    checkOutput("busy",    32'(busy),    32'(m_mode == M_REC));
    checkOutput("done",    32'(done),    32'(m_done));
    checkOutput("rec_len", 32'(rec_len), 32'(m_len));
    if (m_rd_known) begin
      checkOutput("rd_data", 32'(rd_data), 32'(m_rd));
    end
  endtask

  task automatic modelStore(logic [7:0] d);
    if (m_len < DEPTH) begin
      m_mem[m_len]   = d;
      m_known[m_len] = 1'b1;
      m_len++;
    end
  endtask

  // Drives one cycle of inputs (called at a falling edge), predicts the
  // recorder's response, then checks just after the rising edge.
  task automatic applyStimulus(bit a, bit s, bit v, logic [7:0] d, int ra);
    arm          = a;
    stop         = s;
    sample_valid = v;
    sample_in    = d;
    rd_addr      = ADDR_W'(ra);
    m_rd_known   = m_known[ra];
    m_rd         = m_mem[ra];
    m_done       = 1'b0;
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (a) begin
          m_mode = M_ARMED;
          m_len  = 0;
        end
      end
      M_ARMED: begin
        if (s) begin
          m_mode = M_IDLE;
        end else if (v && magnitude(d) >= THRESH) begin
          modelStore(d);
          m_mode = M_REC;
        end
      end
      default: begin
        if (v) begin
          modelStore(d);
        end
        if (s || m_len == DEPTH) begin
          m_mode = M_DONE;
          m_done = 1'b1;
        end
      end
    endcase
    @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
  endtask

  task automatic resetNow();
    rst = 1'b1;
    #1;
    m_mode     = M_IDLE;
    m_len      = 0;
    m_done     = 1'b0;
    m_rd       = 8'd0;
    m_rd_known = 1'b1;
    checkAll();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    arm          = 1'b0;
    stop         = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 8'd128;
    rd_addr      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_known[i] = 1'b0;
      m_mem[i]   = 8'd0;
    end
    m_mode     = M_IDLE;
    m_len      = 0;
    m_done     = 1'b0;
    m_rd       = 8'd0;
    m_rd_known = 1'b1;
    #2;
    checkAll();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] trigger threshold");
    applyStimulus(0, 1, 0, 8'd128, 0);
    applyStimulus(1, 0, 0, 8'd128, 0);
    applyStimulus(0, 0, 1, 8'd128, 0);
    applyStimulus(0, 0, 1, 8'd130, 0);
    applyStimulus(0, 0, 1, 8'd140, 0);
    applyStimulus(0, 0, 1, 8'd150, 0);
    applyStimulus(0, 0, 1, 8'd100, 0);
    applyStimulus(1, 0, 0, 8'd128, 0);
    applyStimulus(0, 1, 0, 8'd128, 0);
    applyStimulus(0, 0, 0, 8'd128, 0);
    applyStimulus(0, 0, 0, 8'd128, 1);
    applyStimulus(0, 0, 0, 8'd128, 1);
    checkOutput("trig_len", 32'(rec_len), 32'd2);

    $display("[TB] stop while armed");
    applyStimulus(1, 0, 0, 8'd128, 0);
    applyStimulus(0, 1, 1, 8'd255, 0);
    applyStimulus(0, 0, 0, 8'd128, 0);
    applyStimulus(0, 1, 0, 8'd128, 0);

    $display("[TB] readback");
    applyStimulus(1, 0, 0, 8'd128, 0);
    applyStimulus(0, 0, 1, 8'd10, 0);
    applyStimulus(0, 0, 1, 8'd250, 0);
    applyStimulus(0, 1, 1, 8'd5, 0);
    applyStimulus(0, 0, 0, 8'd128, 0);
    applyStimulus(0, 0, 0, 8'd128, 1);
    applyStimulus(0, 0, 0, 8'd128, 2);
    applyStimulus(0, 0, 0, 8'd128, 2);
    checkOutput("rb_last", 32'(rd_data), 32'd5);

    $display("[TB] read-before-write collision");
    applyStimulus(1, 0, 0, 8'd128, 0);
    applyStimulus(0, 0, 1, 8'd60, 0);
    applyStimulus(0, 0, 1, 8'd61, 1);
    applyStimulus(0, 1, 0, 8'd128, 1);
    applyStimulus(0, 0, 0, 8'd128, 1);

    $display("[TB] reset mid-capture");
    applyStimulus(1, 0, 0, 8'd128, 0);
    applyStimulus(0, 0, 1, 8'd20, 0);
    applyStimulus(0, 0, 1, 8'd21, 0);
    applyStimulus(0, 0, 1, 8'd22, 0);
    resetNow();
    applyStimulus(1, 0, 0, 8'd128, 0);
    applyStimulus(0, 0, 1, 8'd230, 0);
    applyStimulus(0, 1, 0, 8'd128, 0);
    applyStimulus(0, 0, 0, 8'd128, 0);

    $display("[TB] fill RAM");
    applyStimulus(1, 0, 0, 8'd128, 0);
    applyStimulus(0, 0, 1, 8'd200, 0);
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(0, 0, 1, 8'(i), i - 1);
    end
    checkOutput("full_len", 32'(rec_len), 32'(DEPTH));
    applyStimulus(0, 0, 1, 8'd77, 0);
    applyStimulus(0, 0, 0, 8'd128, 0);
    checkOutput("full_mem0", 32'(rd_data), 32'd200);
    applyStimulus(0, 0, 0, 8'd128, DEPTH - 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 24) == 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 1) == 1,
                    8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
